// File: rtl/microcode_sequencer_if.sv
// Microcode sequencer bus bundle.
// Groups the decoder/microcode-word inputs and the fetch/execute/interrupt
// strobes that pass between the sequencer and the CPU datapath.
//   master : the sequencer (consumes decode/microcode fields, drives strobes)
//   slave  : the datapath / environment (drives decode/microcode fields)
interface microcode_sequencer_if #(
  parameter int MAX_OPS = 2,
  parameter int MS_W    = 3,
  parameter int FLAG_W  = 3
);
  logic [1:0]         op_bytes;
  logic [FLAG_W-1:0]  flags;
  logic               uc_halt;
  logic               uc_last;
  logic [FLAG_W-1:0]  uc_cond_sel;
  logic               uc_cond_neg;
  logic               irq;

  logic               load_origin;
  logic               load_mar_pc;
  logic               oe_ram;
  logic               pc_enable;
  logic               load_ir;
  logic [MAX_OPS-1:0] load_operand;
  logic               exec_en;
  logic               suppress_pc_load;
  logic [MS_W-1:0]    microstep;
  logic               irq_ack;
  logic               load_vector;
  logic               halted;
  logic               error;

  modport master (
    input  op_bytes, flags, uc_halt, uc_last, uc_cond_sel, uc_cond_neg, irq,
    output load_origin, load_mar_pc, oe_ram, pc_enable, load_ir, load_operand,
           exec_en, suppress_pc_load, microstep, irq_ack, load_vector,
           halted, error
  );

  modport slave (
    output op_bytes, flags, uc_halt, uc_last, uc_cond_sel, uc_cond_neg, irq,
    input  load_origin, load_mar_pc, oe_ram, pc_enable, load_ir, load_operand,
           exec_en, suppress_pc_load, microstep, irq_ack, load_vector,
           halted, error
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches an opcode plus up to MAX_OPS operand bytes,
// then steps the microcode ROM address until the word ends the instruction,
// with level interrupts taken only between instructions or from HALT.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - microcode_sequencer_if.master (decode/microcode inputs, strobes out)
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_RESET     | post-reset idle, one cycle
// ST_INIT      | load PC with the origin address
// ST_LATCH_ADDR| MAR <= PC
// ST_READ_BYTE | RAM output enabled, data settling
// ST_LATCH_BYTE| latch opcode/operand byte, PC++
// ST_CHK_MORE  | decide: fetch another byte, execute, or fault
// ST_EXECUTE   | microcode word {IR, microstep} drives the datapath
// ST_IRQ       | acknowledge interrupt, PC <= vector
// ST_HALT      | stopped; wakes on irq unless halted by an error
module microcode_sequencer #(
  parameter int MAX_OPS = 2,
  parameter int MS_W    = 3,
  parameter int FLAG_W  = 3
) (
  input logic                   clk,
  input logic                   reset,
  microcode_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    ST_RESET, ST_INIT, ST_LATCH_ADDR, ST_READ_BYTE, ST_LATCH_BYTE,
    ST_CHK_MORE, ST_EXECUTE, ST_IRQ, ST_HALT
  } state_t;

  state_t          state, state_n;
  logic [MS_W-1:0] microstep, microstep_n;
  logic [2:0]      byte_count, byte_count_n;
  logic            error_q, error_n;

  logic               load_origin, load_mar_pc, oe_ram, pc_enable, load_ir;
  logic [MAX_OPS-1:0] load_operand;
  logic               exec_en, suppress_pc_load, irq_ack, load_vector, halted;
  logic               cond_step, cond_ok, instr_end;

  assign cond_step = |bus.uc_cond_sel;
  assign cond_ok   = |(bus.uc_cond_sel & (bus.uc_cond_neg ? ~bus.flags : bus.flags));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RESET;
      microstep  <= '0;
      byte_count <= '0;
      error_q    <= 1'b0;
    end else begin
      state      <= state_n;
      microstep  <= microstep_n;
      byte_count <= byte_count_n;
      error_q    <= error_n;
    end
  end

  always_comb begin
    state_n          = state;
    microstep_n      = microstep;
    byte_count_n     = byte_count;
    error_n          = error_q;
    load_origin      = 1'b0;
    load_mar_pc      = 1'b0;
    oe_ram           = 1'b0;
    pc_enable        = 1'b0;
    load_ir          = 1'b0;
    load_operand     = '0;
    exec_en          = 1'b0;
    suppress_pc_load = 1'b0;
    irq_ack          = 1'b0;
    load_vector      = 1'b0;
    halted           = 1'b0;
    instr_end        = 1'b0;

    case (state)
      ST_RESET: state_n = ST_INIT;
      ST_INIT: begin
        load_origin = 1'b1;
        state_n     = ST_LATCH_ADDR;
      end
      ST_LATCH_ADDR: begin
        load_mar_pc = 1'b1;
        state_n     = ST_READ_BYTE;
      end
      ST_READ_BYTE: begin
        oe_ram  = 1'b1;
        state_n = ST_LATCH_BYTE;
      end
      ST_LATCH_BYTE: begin
        oe_ram    = 1'b1;
        pc_enable = 1'b1;
        // byte 0 is the opcode; byte i (i>=1) goes to operand latch i-1
        if (byte_count == 3'd0) load_ir = 1'b1;
        for (int i = 0; i < MAX_OPS; i++)
          if (byte_count == 3'(i + 1)) load_operand[i] = 1'b1;
        byte_count_n = byte_count + 3'd1;
        state_n      = ST_CHK_MORE;
      end
      ST_CHK_MORE: begin
        // an opcode claiming more operands than the latches hold is a fault
        if (int'(bus.op_bytes) > MAX_OPS) begin
          error_n      = 1'b1;
          byte_count_n = '0;
          state_n      = ST_HALT;
        end else if (byte_count > {1'b0, bus.op_bytes}) begin
          byte_count_n = '0;
          state_n      = ST_EXECUTE;
        end else begin
          state_n = ST_LATCH_ADDR;
        end
      end
      ST_EXECUTE: begin
        exec_en = 1'b1;
        if (bus.uc_halt) begin
          microstep_n = '0;
          state_n     = ST_HALT;
        end else if (cond_step && !cond_ok) begin
          suppress_pc_load = 1'b1;
          instr_end        = 1'b1;
        end else if (bus.uc_last) begin
          instr_end = 1'b1;
        end else if (microstep == '1) begin
          // ran off the end of the opcode's microcode without a terminator
          error_n     = 1'b1;
          microstep_n = '0;
          state_n     = ST_HALT;
        end else begin
          microstep_n = microstep + MS_W'(1);
        end
        if (instr_end) begin
          microstep_n = '0;
          state_n     = bus.irq ? ST_IRQ : ST_LATCH_ADDR;
        end
      end
      ST_IRQ: begin
        irq_ack     = 1'b1;
        load_vector = 1'b1;
        state_n     = ST_LATCH_ADDR;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (bus.irq && !error_q) state_n = ST_IRQ;
      end
      default: state_n = ST_RESET;
    endcase
  end

  assign bus.load_origin      = load_origin;
  assign bus.load_mar_pc      = load_mar_pc;
  assign bus.oe_ram           = oe_ram;
  assign bus.pc_enable        = pc_enable;
  assign bus.load_ir          = load_ir;
  assign bus.load_operand     = load_operand;
  assign bus.exec_en          = exec_en;
  assign bus.suppress_pc_load = suppress_pc_load;
  assign bus.microstep        = microstep;
  assign bus.irq_ack          = irq_ack;
  assign bus.load_vector      = load_vector;
  assign bus.halted           = halted;
  assign bus.error            = error_q;

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 SHALL have parameter MAX_OPS, default 2: maximum operand bytes per instruction (1..3).
REQ-002 SHALL have parameter MS_W, default 3: microstep counter width (2^MS_W steps per opcode).
REQ-003 SHALL have parameter FLAG_W, default 3: flag vector width (bit0 Z, bit1 C, bit2 N).
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port op_bytes  input  2  operand byte count for the opcode currently in IR (decoder output).
REQ-007 SHALL have port flags  input  FLAG_W  current CPU flags.
REQ-008 SHALL have port uc_halt, uc_last  input  1 each  halt / last_step bits of the addressed microcode word.
REQ-009 SHALL have port uc_cond_sel  input  FLAG_W  one-hot flag select for a conditional step (0 = unconditional).
REQ-010 SHALL have port uc_cond_neg  input  1  condition is satisfied when selected flag is 0.
REQ-011 SHALL have port irq  input  1  level interrupt request.
REQ-012 SHALL have ports load_origin, load_mar_pc, oe_ram, pc_enable, load_ir  output  1 each  fetch strobes.
REQ-013 SHALL have port load_operand  output  MAX_OPS  one-hot operand-latch strobe (bit i = operand i+1).
REQ-014 SHALL have port exec_en  output  1  microcode word at {IR, microstep} drives the datapath this cycle.
REQ-015 SHALL have port suppress_pc_load  output  1  datapath must mask PC-load bits of the current word.
REQ-016 SHALL have port microstep  output  MS_W  microcode ROM step address.
REQ-017 SHALL have ports irq_ack, load_vector  output  1 each  interrupt acknowledge / load PC from vector.
REQ-018 SHALL have ports halted, error  output  1 each  status.

Function
REQ-019 SHALL implement states RESET, INIT, LATCH_ADDR, READ_BYTE, LATCH_BYTE, CHK_MORE, EXECUTE, IRQ, HALT.
REQ-020 SHALL sequence RESET->INIT->LATCH_ADDR, one cycle each; INIT asserts load_origin.
REQ-021 SHALL assert load_mar_pc in LATCH_ADDR and oe_ram in READ_BYTE, then go to the next state.
REQ-022 SHALL in LATCH_BYTE assert oe_ram and pc_enable, plus load_ir when byte_count=0 else load_operand[byte_count-1], then increment byte_count.
REQ-023 SHALL in CHK_MORE go to EXECUTE with byte_count:=0 when byte_count > op_bytes, else to LATCH_ADDR.
REQ-024 SHALL, if op_bytes > MAX_OPS at CHK_MORE, go to HALT with error=1 (no EXECUTE).
REQ-025 SHALL take exactly 4*(op_bytes+1) cycles from first LATCH_ADDR to first EXECUTE cycle.
REQ-026 SHALL assert exec_en in every EXECUTE cycle and in no other state.
REQ-027 SHALL define cond_ok = |(uc_cond_sel & (uc_cond_neg ? ~flags : flags)); conditional step = uc_cond_sel != 0.
REQ-028 SHALL apply EXECUTE priority: uc_halt -> HALT; conditional && !cond_ok -> suppress_pc_load=1, end instruction; uc_last -> end instruction; else microstep+1.
REQ-029 SHALL on instruction end reset microstep to 0 and go to IRQ if irq=1, else LATCH_ADDR.
REQ-030 SHALL, if microstep = 2^MS_W-1 without uc_last/uc_halt, go to HALT with error=1 (no wrap to 0).
REQ-031 SHALL in IRQ assert irq_ack and load_vector for exactly one cycle, then go to LATCH_ADDR.
REQ-032 SHALL never enter IRQ mid-fetch or mid-instruction; irq is sampled only at instruction end or in HALT.
REQ-033 SHALL hold halted=1 in HALT; irq=1 in HALT with error=0 leaves to IRQ (wake), with error=1 is ignored.
REQ-034 SHALL treat a conditional step that is also uc_halt as halt (halt has priority).
REQ-035 SHALL keep all strobes zero in RESET, CHK_MORE and HALT.

Reset
REQ-036 SHALL on reset (any state, any cycle) immediately set state=RESET, microstep=0, byte_count=0, error=0, all outputs 0.
REQ-037 SHALL resume normal sequencing from RESET on the first clk edge after reset deasserts.

Verification
REQ-038 Reset release, op_bytes=0, uc_last=1 at MS0 -> INIT, LATCH_ADDR..CHK_MORE (4 cycles), one exec_en cycle, back to LATCH_ADDR.
REQ-039 op_bytes=2, word MS1 has uc_cond_sel=001, uc_cond_neg=0, flags=000 -> load_operand 01 then 10, EXECUTE MS0..MS1, suppress_pc_load=1 at MS1 only; with flags=001 suppress_pc_load stays 0.
REQ-040 irq=1 asserted during READ_BYTE of a 1-operand instruction -> no ack until that instruction's uc_last; then one cycle irq_ack=load_vector=1, then LATCH_ADDR.
REQ-041 uc_halt=1 at MS0 -> halted=1 next cycle, stays; irq=1 -> IRQ, irq_ack for one cycle, fetch resumes.
REQ-042 op_bytes=3 with MAX_OPS=2 -> HALT, error=1; microcode with no uc_last, MS_W=3 -> HALT after MS7, error=1; later irq ignored.
REQ-043 reset pulsed asynchronously (between edges) during EXECUTE MS2 -> all outputs 0 before next edge, sequence restarts at RESET.
